// File: rtl/sound_event_seq.sv
// Turns one-cycle game events into held, gap-separated tone requests.
// Losses preempt bounces; a single bounce can wait in a pending slot.
module sound_event_seq #(
    parameter int unsigned PRESCALE = 25000,
    parameter int unsigned POINT_MS = 50,
    parameter int unsigned LOSE_MS  = 400,
    parameter int unsigned GAP_MS   = 20
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       paddle_hit,
    input  logic       wall_hit,
    input  logic [1:0] miss,
    output logic [1:0] point,
    output logic [1:0] lose,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY_PT,
        PLAY_LS,
        GAP
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [9:0]  PT_LAST  = 10'(POINT_MS - 1);
    localparam logic [9:0]  LS_LAST  = 10'(LOSE_MS - 1);
    localparam logic [9:0]  GAP_LAST = 10'(GAP_MS - 1);

    state_t      state_q, state_d;
    logic [15:0] pre_q, pre_d;
    logic [9:0]  dur_q, dur_d;
    logic        pend_v_q, pend_v_d;
    logic [1:0]  pend_c_q, pend_c_d;
    logic [1:0]  pt_c_q, pt_c_d;
    logic [1:0]  ls_c_q, ls_c_d;
    logic [1:0]  point_q, point_d;
    logic [1:0]  lose_q, lose_d;
    logic        busy_q, busy_d;

    logic        hit;
    logic [1:0]  hit_code;
    logic        lost;
    logic [9:0]  dur_last;
    logic        tmo;

    always_comb begin
        hit      = paddle_hit | wall_hit;
        hit_code = paddle_hit ? 2'b01 : 2'b10;
        lost     = (miss != 2'b00);

        unique case (state_q)
            PLAY_PT: dur_last = PT_LAST;
            PLAY_LS: dur_last = LS_LAST;
            default: dur_last = GAP_LAST;
        endcase
        tmo = (pre_q == PRE_LAST) && (dur_q == dur_last);

        state_d  = state_q;
        pend_v_d = pend_v_q;
        pend_c_d = pend_c_q;
        pt_c_d   = pt_c_q;
        ls_c_d   = ls_c_q;

        // Any hit not started right away lands in the pending slot.
        unique case (state_q)
            IDLE: begin
                if (lost) begin
                    state_d = PLAY_LS;
                    ls_c_d  = miss;
                    if (hit) begin
                        pend_v_d = 1'b1;
                        pend_c_d = hit_code;
                    end
                end else if (hit) begin
                    state_d = PLAY_PT;
                    pt_c_d  = hit_code;
                end
            end
            PLAY_PT: begin
                if (hit) begin
                    pend_v_d = 1'b1;
                    pend_c_d = hit_code;
                end
                if (lost) begin
                    state_d = PLAY_LS;
                    ls_c_d  = miss;
                end else if (tmo) begin
                    state_d = GAP;
                end
            end
            PLAY_LS: begin
                if (hit) begin
                    pend_v_d = 1'b1;
                    pend_c_d = hit_code;
                end
                if (tmo) state_d = GAP;
            end
            default: begin
                if (hit) begin
                    pend_v_d = 1'b1;
                    pend_c_d = hit_code;
                end
                if (lost) begin
                    state_d = PLAY_LS;
                    ls_c_d  = miss;
                end else if (tmo) begin
                    if (pend_v_d) begin
                        state_d  = PLAY_PT;
                        pt_c_d   = pend_c_d;
                        pend_v_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        pre_d = pre_q;
        dur_d = dur_q;
        if (state_d != state_q) begin
            pre_d = '0;
            dur_d = '0;
        end else if (state_q != IDLE) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                dur_d = dur_q + 10'd1;
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end

        point_d = (state_d == PLAY_PT) ? pt_c_d : 2'b00;
        lose_d  = (state_d == PLAY_LS) ? ls_c_d : 2'b00;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            dur_q    <= '0;
            pend_v_q <= 1'b0;
            pend_c_q <= 2'b00;
            pt_c_q   <= 2'b00;
            ls_c_q   <= 2'b00;
            point_q  <= 2'b00;
            lose_q   <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            dur_q    <= dur_d;
            pend_v_q <= pend_v_d;
            pend_c_q <= pend_c_d;
            pt_c_q   <= pt_c_d;
            ls_c_q   <= ls_c_d;
            point_q  <= point_d;
            lose_q   <= lose_d;
            busy_q   <= busy_d;
        end
    end

    assign point = point_q;
    assign lose  = lose_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sound_event_seq.sv
// Scoreboarded bench for sound_event_seq with short durations.
// Each step pushes the expected {point,lose,busy}, then compares after the edge.
module tb_sound_event_seq;

    logic       clk25 = 1'b0;
    logic       rst = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       wall_hit = 1'b0;
    logic [1:0] miss = 2'b00;
    logic [1:0] point;
    logic [1:0] lose;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    logic [4:0] exp_q[$];

    sound_event_seq #(
        .PRESCALE(4),
        .POINT_MS(3),
        .LOSE_MS(5),
        .GAP_MS(2)
    ) dut (
        .clk25(clk25),
        .rst(rst),
        .paddle_hit(paddle_hit),
        .wall_hit(wall_hit),
        .miss(miss),
        .point(point),
        .lose(lose),
        .busy(busy)
    );

    always #5 clk25 = ~clk25;

    task automatic check(input string tag, input logic [4:0] got,
                         input logic [4:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got p/l/b=%b expected=%b",
                     tag, cyc, got, want);
        end
    endtask

    task automatic ev(input string tag, input logic ph, input logic wh,
                      input logic [1:0] m, input logic r,
                      input logic [1:0] p, input logic [1:0] l,
                      input logic b);
        logic [4:0] e;
        exp_q.push_back({p, l, b});
        paddle_hit = ph;
        wall_hit   = wh;
        miss       = m;
        rst        = r;
        @(posedge clk25);
        #1;
        cyc++;
        paddle_hit = 1'b0;
        wall_hit   = 1'b0;
        miss       = 2'b00;
        rst        = 1'b0;
        e = exp_q.pop_front();
        check(tag, {point, lose, busy}, e);
    endtask

    task automatic hold(input string tag, input logic [1:0] p,
                        input logic [1:0] l, input logic b, input int n);
        for (int i = 0; i < n; i++)
            ev(tag, 1'b0, 1'b0, 2'b00, 1'b0, p, l, b);
    endtask

    initial begin
        ev("reset", 0, 0, 2'b00, 1, 2'b00, 2'b00, 0);
        ev("reset2", 0, 0, 2'b00, 1, 2'b00, 2'b00, 0);

        // 1: reset mid-tone
        ev("t1_hit", 1, 0, 2'b00, 0, 2'b01, 2'b00, 1);
        hold("t1_tone", 2'b01, 2'b00, 1, 4);
        ev("t1_rst", 0, 0, 2'b00, 1, 2'b00, 2'b00, 0);
        hold("t1_quiet", 2'b00, 2'b00, 0, 20);

        // 2: single paddle tone
        ev("t2_hit", 1, 0, 2'b00, 0, 2'b01, 2'b00, 1);
        hold("t2_tone", 2'b01, 2'b00, 1, 11);
        hold("t2_gap", 2'b00, 2'b00, 1, 8);
        hold("t2_idle", 2'b00, 2'b00, 0, 3);

        // 3: everything at once
        ev("t3_all", 1, 1, 2'b11, 0, 2'b00, 2'b11, 1);
        hold("t3_lose", 2'b00, 2'b11, 1, 19);
        hold("t3_gap1", 2'b00, 2'b00, 1, 8);
        hold("t3_pt", 2'b01, 2'b00, 1, 12);
        hold("t3_gap2", 2'b00, 2'b00, 1, 8);
        hold("t3_idle", 2'b00, 2'b00, 0, 2);

        // 4: miss preempts a wall tone
        ev("t4_wall", 0, 1, 2'b00, 0, 2'b10, 2'b00, 1);
        hold("t4_pt", 2'b10, 2'b00, 1, 3);
        ev("t4_miss", 0, 0, 2'b01, 0, 2'b00, 2'b01, 1);
        hold("t4_lose", 2'b00, 2'b01, 1, 19);
        hold("t4_gap", 2'b00, 2'b00, 1, 8);
        hold("t4_idle", 2'b00, 2'b00, 0, 3);

        // 5: newest hit wins while a loss plays
        ev("t5_miss", 0, 0, 2'b01, 0, 2'b00, 2'b01, 1);
        hold("t5_lose", 2'b00, 2'b01, 1, 2);
        ev("t5_wall", 0, 1, 2'b00, 0, 2'b00, 2'b01, 1);
        hold("t5_lose", 2'b00, 2'b01, 1, 1);
        ev("t5_pad", 1, 0, 2'b00, 0, 2'b00, 2'b01, 1);
        hold("t5_lose", 2'b00, 2'b01, 1, 14);
        hold("t5_gap1", 2'b00, 2'b00, 1, 8);
        hold("t5_pt", 2'b01, 2'b00, 1, 12);
        hold("t5_gap2", 2'b00, 2'b00, 1, 8);
        hold("t5_idle", 2'b00, 2'b00, 0, 3);

        // 6: miss during the gap
        ev("t6_hit", 1, 0, 2'b00, 0, 2'b01, 2'b00, 1);
        hold("t6_pt", 2'b01, 2'b00, 1, 11);
        hold("t6_gap", 2'b00, 2'b00, 1, 3);
        ev("t6_miss", 0, 0, 2'b10, 0, 2'b00, 2'b10, 1);
        hold("t6_lose", 2'b00, 2'b10, 1, 19);
        hold("t6_gap2", 2'b00, 2'b00, 1, 8);
        hold("t6_idle", 2'b00, 2'b00, 0, 2);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard_left got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
